// File: rtl/jtag_seq_driver_pkg.sv
// Shared definitions for the JTAG sequencer: TAP state codes, command opcodes,
// driver FSM states, preamble lengths and the IEEE 1149.1 next-state function.
package jtag_seq_driver_pkg;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR   = 4'h0,
        TAP_EXIT1_DR   = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SEL_IR     = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SEL_DR     = 4'h7,
        TAP_EXIT2_IR   = 4'h8,
        TAP_EXIT1_IR   = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_RUN_IDLE   = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_RESET      = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'b00,
        OP_IR_SCAN   = 2'b01,
        OP_DR_SCAN   = 2'b10,
        OP_IDLE_RUN  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        RST_PARK, IDLE, PRE, SHIFT, POST, DRAIN, RESP
    } drv_state_e;

    localparam int IR_PRE_LEN  = 4;
    localparam int DR_PRE_LEN  = 3;
    localparam int RST_PRE_LEN = 6;

    // TMS value for preamble cycle idx, where idx 0 is the first cycle after accept.
    function automatic logic pre_tms(cmd_op_e op, int unsigned idx);
        case (op)
            OP_IR_SCAN:   return idx < 32'd2;
            OP_DR_SCAN:   return idx == 32'd0;
            OP_TAP_RESET: return idx < 32'd5;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic tap_state_e tap_next(tap_state_e s, logic tms);
        case (s)
            TAP_RESET:      return tms ? TAP_RESET      : TAP_RUN_IDLE;
            TAP_RUN_IDLE:   return tms ? TAP_SEL_DR     : TAP_RUN_IDLE;
            TAP_SEL_DR:     return tms ? TAP_SEL_IR     : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: return tms ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   return tms ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   return tms ? TAP_UPDATE_DR  : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   return tms ? TAP_EXIT2_DR   : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   return tms ? TAP_UPDATE_DR  : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  return tms ? TAP_SEL_DR     : TAP_RUN_IDLE;
            TAP_SEL_IR:     return tms ? TAP_RESET      : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: return tms ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   return tms ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   return tms ? TAP_UPDATE_IR  : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   return tms ? TAP_EXIT2_IR   : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   return tms ? TAP_UPDATE_IR  : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  return tms ? TAP_SEL_DR     : TAP_RUN_IDLE;
            default:        return TAP_RESET;
        endcase
    endfunction

endpackage

// File: rtl/jtag_seq_driver_tap_state_mirror.sv
// Register tracking the IEEE 1149.1 TAP state as seen by a target sampling tms.
module tap_state_mirror
    import jtag_seq_driver_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_b,
    input  logic       tms,
    output tap_state_e state
);

    always_ff @(posedge TCK or negedge TRST_b) begin
        if (!TRST_b) begin
            state <= TAP_RESET;
        end else begin
            state <= tap_next(state, tms);
        end
    end

endmodule

// File: rtl/jtag_seq_driver.sv
// TCK-domain JTAG sequencer: walks the TAP with TMS, shifts command data out on
// TDI LSB-first and returns the captured TDO bits with a one-cycle response pulse.
module jtag_seq_driver
    import jtag_seq_driver_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6,
    parameter int TDO_LAT = 1
) (
    input  logic               TCK,
    input  logic               TRST_b,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy
);

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [1:0]       TDO_IDX   = 2'(TDO_LAT);

    drv_state_e         state;
    tap_state_e         tap_state;
    cmd_op_e            op_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   samp_cnt;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap;
    logic [2:0]         shift_hist;

    logic               in_shift;
    logic [3:0]         hist_all;
    logic               sample_now;
    logic               all_sampled;
    logic               is_scan;
    logic               done_now;
    logic [MAX_LEN-1:0] cap_next;
    logic [LEN_W-1:0]   cmd_len_eff;
    logic [LEN_W-1:0]   pre_last;

    tap_state_mirror u_mirror (
        .TCK    (TCK),
        .TRST_b (TRST_b),
        .tms    (TMS),
        .state  (tap_state)
    );

    assign busy = ~cmd_ready;

    // A TDO sample is due TDO_LAT edges after each edge that shifted a bit into the target.
    always_comb begin
        in_shift    = (state == SHIFT);
        hist_all    = {shift_hist, in_shift};
        sample_now  = hist_all[TDO_IDX];
        cap_next    = cap;
        if (sample_now) begin
            cap_next = cap | (MAX_LEN'(TDO) << samp_cnt);
        end
        all_sampled = ((samp_cnt + LEN_W'(sample_now)) == len_q);
        is_scan     = (op_q == OP_IR_SCAN) || (op_q == OP_DR_SCAN);
        cmd_len_eff = ((cmd_len == '0) || (cmd_len > MAX_LEN_W)) ? MAX_LEN_W : cmd_len;
        case (op_q)
            OP_IR_SCAN:   pre_last = LEN_W'(IR_PRE_LEN - 1);
            OP_DR_SCAN:   pre_last = LEN_W'(DR_PRE_LEN - 1);
            OP_TAP_RESET: pre_last = LEN_W'(RST_PRE_LEN - 1);
            default:      pre_last = len_q - LEN_W'(1);
        endcase
        done_now = ((state == PRE) && (cnt == pre_last) && !is_scan)
                || ((state == POST) && (cnt != '0) && all_sampled)
                || ((state == DRAIN) && all_sampled);
    end

    always_ff @(posedge TCK or negedge TRST_b) begin
        if (!TRST_b) begin
            state      <= RST_PARK;
            TMS        <= 1'b1;
            TDI        <= 1'b0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            op_q       <= OP_TAP_RESET;
            len_q      <= '0;
            cnt        <= '0;
            samp_cnt   <= '0;
            data_q     <= '0;
            cap        <= '0;
            shift_hist <= '0;
        end else begin
            shift_hist <= {shift_hist[1:0], in_shift};
            rsp_valid  <= 1'b0;
            if (sample_now) begin
                cap      <= cap_next;
                samp_cnt <= samp_cnt + LEN_W'(1);
            end

            case (state)
                RST_PARK: begin
                    TMS   <= 1'b0;
                    state <= IDLE;
                end
                IDLE, RESP: begin
                    if (cmd_ready && cmd_valid) begin
                        op_q      <= cmd_op_e'(cmd_op);
                        len_q     <= cmd_len_eff;
                        data_q    <= cmd_data;
                        cap       <= '0;
                        samp_cnt  <= '0;
                        cnt       <= '0;
                        TMS       <= pre_tms(cmd_op_e'(cmd_op), 32'd0);
                        cmd_ready <= 1'b0;
                        state     <= PRE;
                    end else begin
                        state <= IDLE;
                        // Only offer commands once our own TMS has parked the TAP in Run-Test/Idle.
                        if (!cmd_ready && (tap_next(tap_state, TMS) == TAP_RUN_IDLE)) begin
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                PRE: begin
                    if (cnt == pre_last) begin
                        cnt <= '0;
                        if (is_scan) begin
                            state  <= SHIFT;
                            TMS    <= (len_q == LEN_W'(1));
                            TDI    <= data_q[0];
                            data_q <= data_q >> 1;
                        end
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                        TMS <= pre_tms(op_q, 32'(cnt) + 32'd1);
                    end
                end
                SHIFT: begin
                    if (cnt == (len_q - LEN_W'(1))) begin
                        state <= POST;
                        cnt   <= '0;
                        TMS   <= 1'b1;
                        TDI   <= 1'b0;
                    end else begin
                        cnt    <= cnt + LEN_W'(1);
                        TMS    <= ((cnt + LEN_W'(2)) == len_q);
                        TDI    <= data_q[0];
                        data_q <= data_q >> 1;
                    end
                end
                POST: begin
                    if (cnt == '0) begin
                        cnt <= LEN_W'(1);
                        TMS <= 1'b0;
                    end else if (!all_sampled) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    TMS <= 1'b0;
                end
                default: begin
                    state <= RST_PARK;
                    TMS   <= 1'b1;
                end
            endcase

            if (done_now) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                cmd_ready <= 1'b1;
                rsp_data  <= cap_next;
                TMS       <= 1'b0;
                TDI       <= 1'b0;
            end
        end
    end

endmodule
